// File: rtl/md5_pkg.sv
// Shared MD5 constants: padding, length field, block byte layout and the round tables used by md5core.
package md5_pkg;

  localparam int STR_LEN_DEFAULT = 19;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic {
    FILL  = 1'b0,
    SLIDE = 1'b1
  } feed_state_t;

  // Message length in bits, placed little-endian in block bytes 56..63.
  function automatic logic [63:0] bitlen(input int n);
    return 64'(n) << 3;
  endfunction

  function automatic int byte_lsb(input int idx);
    return 8 * idx;
  endfunction

  localparam logic [31:0] A0 = 32'h6745_2301;
  localparam logic [31:0] B0 = 32'hefcd_ab89;
  localparam logic [31:0] C0 = 32'h98ba_dcfe;
  localparam logic [31:0] D0 = 32'h1032_5476;

  localparam logic [31:0] K_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts repeat every four steps within a round, so only 16 are stored.
  localparam logic [4:0] S_TABLE [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [4:0] shift_amt(input int step);
    return S_TABLE[4 * (step / 16) + (step % 4)];
  endfunction

endpackage

// File: rtl/md5_window_feed.sv
// Sliding window of the last STR_LEN text bytes, emitted as a padded single-block MD5 message per accepted byte.
module md5_window_feed
  import md5_pkg::*;
#(
  parameter int STR_LEN = STR_LEN_DEFAULT,
  parameter int POS_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [511:0]     m_out,
  output logic             valid_out,
  output logic [POS_W-1:0] pos_out
);

  localparam int CNT_W = $clog2(STR_LEN + 1);
  localparam int WIN_W = 8 * STR_LEN;

  // Handshake: a byte is taken on a rising edge where data_valid && data_ready;
  // data_ready depends only on en and reset_n, never on data_valid.
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] win_fill;
  logic [WIN_W-1:0] win_shift;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] fill_base;
  feed_state_t      state;
  feed_state_t      state_base;
  logic             primed;
  logic             accept;

  always_comb begin
    data_ready = en && reset_n;
    accept     = data_valid && data_ready;
    // clear restarts the text in the same cycle, so an accompanying byte becomes character 0.
    fill_base  = clear ? '0 : fill_cnt;
    state_base = clear ? FILL : state;

    win_fill = win;
    if (fill_base < CNT_W'(STR_LEN)) win_fill[byte_lsb(int'(fill_base)) +: 8] = data_in;

    win_shift = win >> 8;
    win_shift[WIN_W-8 +: 8] = data_in;
  end

  // Padding is constant; it is only shown once a block has ever been produced so reset reads as all zero.
  always_comb begin
    m_out = '0;
    if (primed) begin
      m_out[WIN_W-1:0]  = win;
      m_out[WIN_W +: 8] = PAD_BYTE;
      m_out[448 +: 64]  = bitlen(STR_LEN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win       <= '0;
      fill_cnt  <= '0;
      state     <= FILL;
      primed    <= 1'b0;
      valid_out <= 1'b0;
      pos_out   <= '0;
    end else if (en) begin
      valid_out <= 1'b0;
      if (clear) begin
        fill_cnt <= '0;
        state    <= FILL;
        pos_out  <= '0;
      end
      if (accept) begin
        if (state_base == FILL) begin
          win <= win_fill;
          if (fill_base == CNT_W'(STR_LEN - 1)) begin
            state     <= SLIDE;
            fill_cnt  <= CNT_W'(STR_LEN);
            valid_out <= 1'b1;
            pos_out   <= '0;
            primed    <= 1'b1;
          end else begin
            fill_cnt <= fill_base + 1'b1;
          end
        end else begin
          win       <= win_shift;
          valid_out <= 1'b1;
          pos_out   <= pos_out + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/md5_window_feed.md
Name: md5_window_feed

Overview:
- Upstream feeder for the 64-stage md5core pipeline.
- Accepts the challenge text as a byte stream and keeps a sliding window of the last STR_LEN characters.
- For every accepted byte after the window first fills, it emits one fully padded 512-bit MD5 block, so md5core hashes every STR_LEN-character substring back-to-back.
- Alongside each block it emits the substring's start offset, used for match reporting.

Parameters:
- STR_LEN, 19, characters per substring; legal range 1..55 (single-block MD5).
- POS_W, 32, width of the substring position counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global pipeline enable, shared with md5core; when 0 all state holds
- clear  in  1  start of a new text; restarts window fill and position
- data_in  in  8  next text character
- data_valid  in  1  data_in is valid
- data_ready  out  1  byte accepted this cycle when data_valid && data_ready
- m_out  out  512  padded MD5 block, connects to md5core m_in
- valid_out  out  1  m_out holds a complete window, connects to md5core valid_in
- pos_out  out  POS_W  offset in the text of m_out's first character

Behaviour:
- Reset, asynchronous on reset_n=0, all registers cleared:
  - m_out = 0, valid_out = 0, pos_out = 0, data_ready = 0.
  - Window bytes = 0, fill_cnt = 0, state = FILL.
- data_ready = en && reset_n, combinational. Accept = data_valid && data_ready.
- Block layout: block byte i lives at m_out[8*i +: 8], so MD5 word g = m_out[32*g +: 32], little-endian.
  - Bytes 0..STR_LEN-1: window, oldest character at byte 0.
  - Byte STR_LEN: 8'h80.
  - Bytes STR_LEN+1..55: 0.
  - Bytes 56..63: 64-bit bit length, STR_LEN*8, little-endian. For 19 this is byte56 = 8'h98 and the rest 0.
- Padding bytes are constant. Only the window bytes are registered state; m_out is assembled from the window and constants.
- States:
  - FILL (fill_cnt < STR_LEN):
    - Accept shifts the byte into position fill_cnt and increments fill_cnt.
    - When the increment reaches STR_LEN, move to SLIDE, set valid_out = 1 next cycle, pos_out = 0.
  - SLIDE:
    - Accept shifts the window down one byte (byte0 dropped, new byte at STR_LEN-1).
    - valid_out = 1 next cycle; pos_out increments by 1 and wraps modulo 2^POS_W.
- Latency: one clock from the accepting edge to m_out/valid_out.
- A cycle with en=1 and no accept drives valid_out = 0. m_out and pos_out hold their last values.
- en=0: every register holds, including valid_out. This matches the md5core stall, which never drops or duplicates a block.
- clear (sampled only when en=1):
  - Forces fill_cnt = 0, state = FILL, valid_out = 0, pos_out = 0.
  - If accept occurs in the same cycle, that byte becomes character 0 of the new text (fill_cnt = 1).
  - Window bytes beyond fill_cnt are don't-care and are never exposed, because valid_out requires a full window.
- STR_LEN = 1: every accepted byte produces a block, and FILL lasts a single byte.
- reset_n asserted mid-stream: immediate clear to reset values. The next text starts from FILL.
- data_in is ignored when data_valid = 0.

Decomposition:
- Shared package md5_pkg:
  - STR_LEN default.
  - MD5 padding constants: PAD_BYTE = 8'h80, length-field function bitlen(STR_LEN).
  - Block byte-index helper.
- Also move md5core's a0..d0, k and s tables into md5_pkg so both blocks share one source.
- No sub-module. FILL/SLIDE is a 1-bit state plus fill_cnt, contained in this block.

Test Plan:
- Reset then feed "The quick brown fox" (19 bytes, en=1):
  - valid_out = 0 for the first 18 accepts, then 1 one cycle after the 19th.
  - m_out[7:0] = 8'h54 ('T'), m_out[151:144] = 8'h78 ('x'), m_out[159:152] = 8'h80, m_out[455:448] = 8'h98, all other pad bits 0; pos_out = 0.
- Continue with "!":
  - m_out bytes 0..18 = "he quick brown fox!", pos_out = 1, valid_out one cycle.
  - Pipe into md5core: output equals MD5 of "he quick brown fox!".
- Stream 25 bytes with en toggled 0/1 every other cycle:
  - Exactly 7 valid blocks, pos_out 0..6, no duplicates or drops.
  - Outputs frozen during en=0 cycles; data_ready low then.
- clear pulsed with a simultaneous byte 'A' in SLIDE:
  - valid_out = 0 next cycle.
  - 18 further bytes are needed before the next valid, whose block byte0 = 8'h41 and pos_out = 0.
- Assert reset_n low for a partial cycle mid-stream:
  - All outputs 0 asynchronously.
  - After release, 19 bytes are required before valid_out.
- Preload pos counter to 32'hFFFF_FFFF (force) in SLIDE, accept one byte:
  - pos_out wraps to 0, valid_out = 1.
